// File: rtl/mem_arbiter_if.sv
// Pipeline-side and memory-bus signals of the fetch/mem-stage memory arbiter.
// master is the arbiter's view; slave is the pipeline-plus-memory environment.
interface mem_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        stall;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ok;

  modport master (
    input  inst_req, inst_addr, data_req, data_we, data_wstrb, data_addr, data_wdata,
           mem_rdata, mem_ok,
    output inst_rdata, data_rdata, stall, bus_err,
           mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
  );

  modport slave (
    output inst_req, inst_addr, data_req, data_we, data_wstrb, data_addr, data_wdata,
           mem_rdata, mem_ok,
    input  inst_rdata, data_rdata, stall, bus_err,
           mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises the mem-stage access (first) and the
// fetch (second) of one request set onto a shared bus, with a hang watchdog.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, DATA, INST, RESP} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      state;
  state_t      next_state;
  logic        pend_i;
  logic [15:0] wd_cnt;
  logic        err_flag;
  logic        timeout;
  logic        done;
  logic        in_access;
  logic [31:0] rdata_in;

  // An expired watchdog completes the access exactly like mem_ok, with zero data.
  assign in_access = (state == DATA) || (state == INST);
  assign timeout   = !bus.mem_ok && (wd_cnt == TIMEOUT_CNT);
  assign done      = bus.mem_ok || timeout;
  assign rdata_in  = timeout ? 32'h0 : bus.mem_rdata;

  // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.data_req)      next_state = DATA;
        else if (bus.inst_req) next_state = INST;
      end
      DATA: if (done) next_state = pend_i ? INST : RESP;
      INST: if (done) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Requests are ignored in RESP: they still describe the set just completed.
  always_comb begin
    bus.mem_req = rst && in_access;
    bus.bus_err = rst && (state == RESP) && err_flag;
    bus.stall   = 1'b0;
    if (rst) begin
      case (state)
        IDLE:       bus.stall = bus.inst_req || bus.data_req;
        DATA, INST: bus.stall = 1'b1;
        default:    bus.stall = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      pend_i         <= 1'b0;
      wd_cnt         <= '0;
      err_flag       <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_wstrb  <= 4'h0;
      bus.mem_addr   <= 32'h0;
      bus.mem_wdata  <= 32'h0;
      bus.inst_rdata <= 32'h0;
      bus.data_rdata <= 32'h0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (bus.data_req) begin
            pend_i        <= bus.inst_req;
            bus.mem_we    <= bus.data_we;
            bus.mem_wstrb <= bus.data_we ? bus.data_wstrb : 4'h0;
            bus.mem_addr  <= bus.data_addr;
            bus.mem_wdata <= bus.data_wdata;
          end else if (bus.inst_req) begin
            pend_i        <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_wstrb <= 4'h0;
            bus.mem_addr  <= {bus.inst_addr[31:2], 2'b00};
            bus.mem_wdata <= 32'h0;
          end
        end
        DATA: begin
          if (done) begin
            if (!bus.mem_we) bus.data_rdata <= rdata_in;
            if (timeout)     err_flag       <= 1'b1;
            wd_cnt <= '0;
            if (pend_i) begin
              pend_i        <= 1'b0;
              bus.mem_we    <= 1'b0;
              bus.mem_wstrb <= 4'h0;
              bus.mem_addr  <= {bus.inst_addr[31:2], 2'b00};
              bus.mem_wdata <= 32'h0;
            end
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        INST: begin
          if (done) begin
            bus.inst_rdata <= rdata_in;
            if (timeout) err_flag <= 1'b1;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        RESP: err_flag <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected bus accesses and
// per-set results; a monitor pops and compares; a responder plays the memory.
module tb_mem_arbiter;
  localparam int unsigned TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk_wdata;
    int unsigned len;
  } acc_t;

  typedef struct {
    int          n;
    bit          b2b;
    logic [31:0] inst_rdata;
    logic [31:0] data_rdata;
    logic        bus_err;
  } set_t;

  typedef struct {
    int unsigned w;
    logic [31:0] rdata;
  } rsp_t;

  acc_t acc_q[$];
  set_t set_q[$];
  rsp_t rsp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] m_data = 32'h0;
  bit   mon_en  = 1'b1;
  bit   resp_en = 1'b1;
  logic force_ok = 1'b0;
  logic [31:0] force_rdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a set is its data access (if any) then its fetch (if any).
  task automatic add_set(input bit has_d, input bit we, input logic [3:0] wstrb,
                         input logic [31:0] daddr, input logic [31:0] wdata,
                         input int unsigned wd, input logic [31:0] rd_d,
                         input bit has_i, input logic [31:0] iaddr,
                         input int unsigned wi, input logic [31:0] rd_i, input bit b2b);
    set_t s;
    acc_t a;
    rsp_t r;
    s.n = 0;
    s.b2b = b2b;
    s.bus_err = 1'b0;
    if (has_d) begin
      a.we = we;
      a.wstrb = we ? wstrb : 4'h0;
      a.addr = daddr;
      a.wdata = wdata;
      a.chk_wdata = 1'b1;
      a.len = ((wd > TIMEOUT) ? TIMEOUT : wd) + 1;
      acc_q.push_back(a);
      r.w = wd; r.rdata = rd_d;
      rsp_q.push_back(r);
      s.n++;
      if (wd > TIMEOUT) s.bus_err = 1'b1;
      if (!we) m_data = (wd > TIMEOUT) ? 32'h0 : rd_d;
    end
    if (has_i) begin
      a.we = 1'b0;
      a.wstrb = 4'h0;
      a.addr = iaddr & 32'hFFFF_FFFC;
      a.wdata = 32'h0;
      a.chk_wdata = 1'b0;
      a.len = ((wi > TIMEOUT) ? TIMEOUT : wi) + 1;
      acc_q.push_back(a);
      r.w = wi; r.rdata = rd_i;
      rsp_q.push_back(r);
      s.n++;
      if (wi > TIMEOUT) s.bus_err = 1'b1;
      m_inst = (wi > TIMEOUT) ? 32'h0 : rd_i;
    end
    s.inst_rdata = m_inst;
    s.data_rdata = m_data;
    set_q.push_back(s);
  endtask

  // Flow control only: waits for the cycle in which the pipeline is released.
  task automatic wait_resp();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.stall !== 1'b0 && n < 64);
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL resp_wait: stall still %b after %0d cycles", bus.stall, n);
    end
  endtask

  task automatic run_set(input bit has_d, input bit we, input logic [3:0] wstrb,
                         input logic [31:0] daddr, input logic [31:0] wdata,
                         input int unsigned wd, input logic [31:0] rd_d,
                         input bit has_i, input logic [31:0] iaddr,
                         input int unsigned wi, input logic [31:0] rd_i, input bit b2b);
    @(posedge clk); #1;
    bus.data_req   = has_d;
    bus.data_we    = we;
    bus.data_wstrb = wstrb;
    bus.data_addr  = daddr;
    bus.data_wdata = wdata;
    bus.inst_req   = has_i;
    bus.inst_addr  = iaddr;
    add_set(has_d, we, wstrb, daddr, wdata, wd, rd_d, has_i, iaddr, wi, rd_i, b2b);
    wait_resp();
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.data_req = 1'b0;
    bus.inst_req = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  // Memory model: each access completes after its queued wait count, or never.
  initial begin : responder
    rsp_t cur;
    bit active = 1'b0;
    int unsigned cnt = 0;
    cur.w = 0;
    cur.rdata = 32'h0;
    bus.mem_ok = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      bus.mem_ok = 1'b0;
      bus.mem_rdata = $urandom;
      if (!resp_en) begin
        active = 1'b0;
        bus.mem_ok = force_ok;
        if (force_ok) bus.mem_rdata = force_rdata;
      end else if (!rst) begin
        active = 1'b0;
      end else if (bus.mem_req) begin
        if (!active) begin
          if (rsp_q.size() > 0) cur = rsp_q.pop_front();
          else begin cur.w = 0; cur.rdata = 32'h0; end
          cnt = 0;
          active = 1'b1;
        end
        if (cnt == cur.w) begin
          bus.mem_ok = 1'b1;
          bus.mem_rdata = cur.rdata;
        end
        if (cnt == cur.w || cnt == TIMEOUT) active = 1'b0;
        cnt++;
      end
    end
  end

  initial begin : monitor
    set_t s;
    acc_t a;
    bit ok;
    bit err_next = 1'b0;
    int last_resp = -10;
    forever begin
      @(negedge clk);
      if (err_next) begin
        check("bus_err_after_resp", bus.bus_err, 1'b0);
        err_next = 1'b0;
      end
      if (mon_en && rst && bus.stall === 1'b1 && bus.mem_req === 1'b0) begin
        if (set_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_set: stall=1 with no request set outstanding (cycle %0d)", cyc);
        end else begin
          s = set_q.pop_front();
          if (s.b2b) check("b2b_gap", cyc - last_resp, 1);
          for (int k = 0; k < s.n; k++) begin
            a = acc_q.pop_front();
            @(negedge clk);
            check("mem_req", bus.mem_req, 1'b1);
            check("mem_we", bus.mem_we, a.we);
            check("mem_wstrb", bus.mem_wstrb, a.wstrb);
            check("mem_addr", bus.mem_addr, a.addr);
            if (a.chk_wdata) check("mem_wdata", bus.mem_wdata, a.wdata);
            ok = (bus.stall === 1'b1);
            for (int c = 1; c < a.len; c++) begin
              @(negedge clk);
              ok &= (bus.mem_req === 1'b1 && bus.stall === 1'b1 && bus.bus_err === 1'b0);
            end
            check("access_hold", ok, 1'b1);
          end
          @(negedge clk);
          check("resp_mem_req", bus.mem_req, 1'b0);
          check("resp_stall", bus.stall, 1'b0);
          check("resp_bus_err", bus.bus_err, s.bus_err);
          check("inst_rdata", bus.inst_rdata, s.inst_rdata);
          check("data_rdata", bus.data_rdata, s.data_rdata);
          last_resp = cyc;
          err_next = 1'b1;
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] a32;
    bit hd, hi, we, b2b;
    int unsigned wd, wi;

    bus.inst_req = 1'b1;
    bus.inst_addr = 32'h8000_0123;
    bus.data_req = 1'b0;
    bus.data_we = 1'b0;
    bus.data_wstrb = 4'h0;
    bus.data_addr = 32'h0;
    bus.data_wdata = 32'h0;

    // Reset held with a fetch pending: pipeline must not stall, bus must stay idle.
    repeat (3) begin
      @(negedge clk);
      check("rst_stall", bus.stall, 1'b0);
      check("rst_mem_req", bus.mem_req, 1'b0);
    end
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_inst_rdata", bus.inst_rdata, 32'h0);
    check("rst_data_rdata", bus.data_rdata, 32'h0);
    check("rst_bus_err", bus.bus_err, 1'b0);

    @(posedge clk); #1;
    add_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h8000_0123, 0, 32'h1111_2222, 1'b0);
    rst = 1'b1;
    wait_resp();
    idle(2);

    // Fetch only, zero-wait.
    run_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'hBFC0_0006, 0, 32'h2408_0001, 1'b0);
    idle(1);
    // Load that sets data_rdata, so the later store and abort are visible.
    run_set(1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0, 1, 32'h1234_5678, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    idle(1);
    // Store plus fetch, two wait states each.
    run_set(1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D, 2, 32'h5555_AAAA,
            1'b1, 32'h0000_0104, 2, 32'h3C01_0040, 1'b0);
    idle(2);
    // Load that never completes: aborted after TIMEOUT+1 cycles.
    run_set(1'b1, 1'b0, 4'h0, 32'h0000_0024, 32'h0, 20, 32'h9999_9999, 1'b0, 32'h0, 0, 32'h0, 1'b0);
    idle(1);
    // Fetch that completes on the very cycle the watchdog would fire.
    run_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h0000_0200, TIMEOUT, 32'h0BAD_F00D, 1'b0);
    idle(1);
    // Back-to-back fetches with inst_req held through RESP.
    run_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h0000_0300, 0, 32'hA0A0_0001, 1'b0);
    run_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h0000_0300, 1, 32'hA0A0_0002, 1'b1);
    run_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h0000_0304, 0, 32'hA0A0_0003, 1'b1);
    idle(2);

    // Reset in the middle of a data access, then a stray mem_ok afterwards.
    mon_en = 1'b0;
    resp_en = 1'b0;
    force_ok = 1'b0;
    @(posedge clk); #1;
    bus.data_req = 1'b1;
    bus.data_we = 1'b0;
    bus.data_addr = 32'h0000_0040;
    @(negedge clk);
    @(negedge clk);
    check("mid_data_mem_req", bus.mem_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.data_req = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_req", bus.mem_req, 1'b0);
    check("mid_rst_stall", bus.stall, 1'b0);
    @(negedge clk);
    check("mid_rst_mem_addr", bus.mem_addr, 32'h0);
    check("mid_rst_data_rdata", bus.data_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    force_ok = 1'b1;
    force_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    force_ok = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("late_ok_mem_req", bus.mem_req, 1'b0);
      check("late_ok_stall", bus.stall, 1'b0);
      check("late_ok_data_rdata", bus.data_rdata, 32'h0);
    end
    m_data = 32'h0;
    m_inst = 32'h0;
    resp_en = 1'b1;
    mon_en = 1'b1;

    // Randomised sets: mixed loads/stores/fetches, wait states, aborts, spacing.
    b2b = 1'b0;
    for (int i = 0; i < 60; i++) begin
      hd = $urandom_range(0, 1);
      hi = $urandom_range(0, 1);
      if (!hd && !hi) hi = 1'b1;
      we = $urandom_range(0, 1);
      wd = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 3);
      wi = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 3);
      a32 = $urandom;
      run_set(hd, we, 4'($urandom), $urandom, $urandom, wd, $urandom,
              hi, a32, wi, $urandom, b2b);
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b) idle($urandom_range(1, 3));
    end
    idle(3);

    check("sets_left", set_q.size(), 0);
    check("accesses_left", acc_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one memory bus between the fetch stage (instruction reads) and the mem stage (data loads/stores) of the 5-stage pipeline. It sequences both stages' outstanding requests onto the bus, data first, then instruction. It holds a pipeline-wide stall until every request sampled in the same cycle has completed, and aborts hung bus transactions with a watchdog.

## Interface
Parameters:
- TIMEOUT, 255: max cycles waiting for mem_ok before abort (1..65535)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- inst_req  in  1  fetch stage requests a read at inst_addr; level, held until the pipeline advances
- inst_addr  in  32  fetch address (PCF)
- inst_rdata  out  32  fetched word; registered, held until next instruction completion
- data_req  in  1  mem stage access request; level
- data_we  in  1  1 = store, 0 = load
- data_wstrb  in  4  store byte enables
- data_addr  in  32  data address (ALUOutM)
- data_wdata  in  32  store data (WriteDataM)
- data_rdata  out  32  load result; registered, held until next load completion
- stall  out  1  freeze whole pipeline while 1
- bus_err  out  1  one-cycle pulse in RESP when any access in the set timed out
- mem_req  out  1  bus request, held until mem_ok or abort
- mem_we  out  1  bus write enable
- mem_wstrb  out  4  bus byte enables (0000 for reads)
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_rdata  in  32  bus read data, valid when mem_ok=1
- mem_ok  in  1  one-cycle completion pulse; may assert in the first cycle mem_req=1

## Operation
- States: IDLE, DATA, INST, RESP.
- IDLE:
  - data_req=1: go to DATA; latch pend_i=inst_req; register data_addr/we/wstrb/wdata onto mem_*.
  - Else inst_req=1: go to INST; register {inst_addr[31:2],2'b00}, we=0, wstrb=0000.
  - Else stay in IDLE.
- DATA, on mem_ok:
  - If the access is a load, capture mem_rdata into data_rdata. Stores leave data_rdata unchanged.
  - If pend_i=1, go to INST and load instruction bus fields. Else go to RESP.
- INST, on mem_ok: capture mem_rdata into inst_rdata; go to RESP.
- RESP: always go to IDLE. inst_req and data_req are ignored in RESP, because they still describe the completed set.
- mem_req = (state==DATA)|(state==INST). mem_we, mem_wstrb, mem_addr and mem_wdata are registered and change only on state entry.
- stall:
  - IDLE: inst_req|data_req.
  - DATA or INST: 1.
  - RESP: 0.
  - Forced 0 while rst=0.
- Watchdog:
  - A 16-bit counter clears on entry to DATA or INST and increments each cycle there without mem_ok.
  - When it reaches TIMEOUT, treat the cycle as mem_ok with rdata=32'h0 and set sticky err_flag.
  - Transitions are then the same as for mem_ok.
  - bus_err = err_flag in RESP; err_flag clears on RESP exit.
- Reset (rst=0), including mid-transaction:
  - State goes to IDLE. mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, inst_rdata, data_rdata, bus_err and err_flag all go to 0.
  - The outstanding bus transaction is abandoned. A late mem_ok after reset is ignored because mem_ok is ignored in IDLE and RESP.

## Timing
- Requests sampled at cycle 0 in IDLE; mem_req first high in cycle 1.
- Zero-wait memory (mem_ok in first mem_req cycle):
  - Single access: RESP in cycle 2; stall low in cycle 2; pipeline advances at end of cycle 2.
  - Data+inst set: DATA in cycle 1, INST in cycle 2, RESP in cycle 3.
- Wait states: each cycle of bus latency adds one cycle to the state it occurs in.
- Minimum spacing between sets is 3 cycles (IDLE, access, RESP).
- inst_rdata and data_rdata are valid from RESP onward and stable until overwritten.
- Abort timing: the access lasts TIMEOUT+1 cycles including the abort cycle.

## Test plan
- Reset with inst_req=1: stall=0 and mem_req=0 throughout. After rst=1, cycle 0 IDLE with stall=1, then mem_req=1 with mem_addr=inst_addr[31:2]<<2.
- Fetch only, inst_addr=32'hBFC0_0006, zero-wait mem_rdata=32'h2408_0001:
  - mem_addr=32'hBFC0_0004, mem_we=0, mem_wstrb=0000.
  - stall pattern 1,1,0.
  - inst_rdata=32'h2408_0001 from cycle 2.
- Simultaneous store (addr 32'h10, wdata 32'hCAFE_F00D, wstrb 1111) and fetch, memory 2 wait states each:
  - Store issued first, fetch second, stall high 7 cycles, then RESP.
  - data_rdata unchanged.
- Load with mem_ok never asserted, TIMEOUT=4: abort after 5 cycles; data_rdata=0; bus_err pulses exactly once in RESP.
- Reset asserted mid-DATA, then mem_ok pulses after reset release: state IDLE, mem_req=0; the late mem_ok is ignored and data_rdata stays 0.
- Back-to-back fetches, req held high through RESP: exactly one bus access per set; next access begins the cycle after RESP.
